fe_frame_tx: RTL

Clocked, parametrised successor to the Fe handshake sender. On a frame-enable request it captures a DATA_W-bit word and sends it as 2-bit symbols (bit1,bit0), least significant pair first. Each symbol uses a 4-phase req/ack handshake (dt/ack), and the frame closes with a senack confirmation. Adds a timeout and error state. Sits between the frame source and the link/receiver logic.

---
 rtl/fe_frame_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fe_frame_tx.sv
// Purpose: send a captured DATA_W-bit word as 2-bit symbols over a 4-phase dt/ack link, then close with senack.
// Latency: fe sampled in cycle n -> cclear in n+1 -> first dt in n+2 at earliest; done pulses one cycle in IDLE.
// Backpressure: every symbol waits for ack rise/fall, the frame waits for senack; TO_CYC stalled cycles -> ERR.
// Optional build macro PARITY_EN appends an even-parity symbol {1'b0, ^word} after the data symbols.
module fe_frame_tx #(
  parameter int DATA_W = 8,
  parameter int TO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack,
  input  logic              senack,
  output logic              bit0,
  output logic              bit1,
  output logic              dt,
  output logic              cclear,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NSYM = DATA_W / 2;
`ifdef PARITY_EN
  localparam int NFRM = NSYM + 1;
  localparam int SW   = DATA_W + 2;
`else
  localparam int NFRM = NSYM;
  localparam int SW   = DATA_W;
`endif
  localparam int CW = $clog2(NFRM + 1);
  localparam int TW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SEND    = 3'd2,
    S_WAITREL = 3'd3,
    S_WAITSEN = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] sreg;
  logic [CW-1:0] sym_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_flag;
  logic          last_sym;
  logic          to_hit;
  logic          waiting;

  assign last_sym = (sym_cnt == CW'(NFRM - 1));
  // The counter sits at TO_CYC-1 during the TO_CYC-th stalled cycle, so ERR follows exactly TO_CYC cycles.
  assign to_hit   = (TO_CYC != 0) && (to_cnt == TW'(TO_CYC - 1));
  assign waiting  = (state == S_CLEAR) || (state == S_SEND) ||
                    (state == S_WAITREL) || (state == S_WAITSEN);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a legitimate handshake step wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (fe) state_nxt = S_CLEAR;
      S_CLEAR:   if (!ack) state_nxt = S_SEND;
                 else if (to_hit) state_nxt = S_ERR;
      S_SEND:    if (ack) state_nxt = S_WAITREL;
                 else if (to_hit) state_nxt = S_ERR;
      S_WAITREL: if (!ack) state_nxt = last_sym ? S_WAITSEN : S_SEND;
                 else if (to_hit) state_nxt = S_ERR;
      S_WAITSEN: if (senack) state_nxt = S_IDLE;
                 else if (to_hit) state_nxt = S_ERR;
      S_ERR:     if (!fe) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: word capture/shift, symbol count, stall timer and the done marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg      <= '0;
      sym_cnt   <= '0;
      to_cnt    <= '0;
      done_flag <= 1'b0;
    end else begin
      if (state == S_CLEAR) begin
`ifdef PARITY_EN
        sreg <= {1'b0, ^data_in, data_in};
`else
        sreg <= data_in;
`endif
        sym_cnt <= '0;
      end else if (state == S_WAITREL && !ack) begin
        sreg    <= sreg >> 2;
        sym_cnt <= sym_cnt + 1'b1;
      end
      if (state_nxt != state)           to_cnt <= '0;
      else if (waiting && TO_CYC != 0)  to_cnt <= to_cnt + 1'b1;
      done_flag <= (state == S_WAITSEN) && (state_nxt == S_IDLE);
    end
  end

  // Moore output decode from registered state and shift register.
  always_comb begin
    bit0   = 1'b0;
    bit1   = 1'b0;
    dt     = 1'b0;
    cclear = 1'b0;
    busy   = (state != S_IDLE);
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      S_IDLE:    done   = done_flag;
      S_CLEAR:   cclear = 1'b1;
      S_SEND: begin
        dt   = 1'b1;
        bit0 = sreg[0];
        bit1 = sreg[1];
      end
      S_WAITREL: begin
        bit0 = sreg[0];
        bit1 = sreg[1];
      end
      S_ERR:     err = 1'b1;
      default: ;
    endcase
  end

endmodule
